// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake with timeout, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_data,
    input  logic [4:0]  ex_rd_addr,
    input  logic [2:0]  ex_func3,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [4:0]  fwd_rd_addr,
    output logic [31:0] fwd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        bus_err
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    // Counter value in the last permitted wait cycle; it reads 0 in the first wait cycle.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    logic        m_valid_q, m_reg_write_q, m_mem_read_q, m_mem_write_q, m_mem_to_reg_q;
    logic [31:0] m_alu_q, m_data_q;
    logic [4:0]  m_rd_q;
    logic [2:0]  m_func3_q;

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        wb_valid_q, wb_valid_d, wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic        mem_op, mem_go, misaligned, timeout, size_b, size_h;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign off    = m_alu_q[1:0];
    assign mem_op = m_valid_q && (m_mem_read_q || m_mem_write_q);

    // Unlisted func3 encodings fall through to word accesses.
    always_comb begin
        if (m_mem_write_q) begin
            size_b = (m_func3_q == 3'b000);
            size_h = (m_func3_q == 3'b001);
        end else begin
            size_b = (m_func3_q[1:0] == 2'b00);
            size_h = (m_func3_q[1:0] == 2'b01);
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = mem_op && ((size_h && off[0]) || (!size_b && !size_h && (off != 2'b00)));
    assign misalign   = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign mem_go  = mem_op && !misaligned;
    assign timeout = mem_go && !dmem_ready && (wait_cnt_q == WaitLast);

    always_comb begin
        ld_byte = 8'(dmem_rdata >> {off, 3'b000});
        ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (size_b) begin
            ld_data = m_func3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_h) begin
            ld_data = m_func3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end else begin
            ld_data = dmem_rdata;
        end
    end

    always_comb begin
        if (size_b) begin
            dmem_wstrb = 4'b0001 << off;
            dmem_wdata = {4{m_data_q[7:0]}};
        end else if (size_h) begin
            dmem_wstrb = 4'b0011 << off;
            dmem_wdata = {2{m_data_q[15:0]}};
        end else begin
            dmem_wstrb = 4'hF;
            dmem_wdata = m_data_q;
        end
    end

    assign dmem_addr   = {m_alu_q[31:2], 2'b00};
    assign fwd_rd_addr = (m_valid_q && m_reg_write_q) ? m_rd_q : 5'd0;
    assign fwd_data    = m_alu_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mem_go && !dmem_ready && !timeout) state_d = StBusy;
            StBusy: if (!mem_go || dmem_ready || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        wait_cnt_d = (state_d == StBusy) ? wait_cnt_q + 8'd1 : 8'd0;
    end

    // FSM: outputs; an abort releases the stall in the same cycle it is signalled
    always_comb begin
        dmem_req  = mem_go;
        dmem_we   = mem_go && m_mem_write_q;
        mem_stall = mem_go && !dmem_ready && !timeout;
        bus_err   = timeout;
    end

    always_comb begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        if (m_valid_q) begin
            wb_rd_d   = m_rd_q;
            wb_data_d = m_alu_q;
            if (!mem_op) begin
                wb_valid_d     = 1'b1;
                wb_reg_write_d = m_reg_write_q && (m_rd_q != 5'd0);
            end else if (misaligned || timeout) begin
                wb_valid_d = 1'b1;
            end else if (dmem_ready) begin
                wb_valid_d = 1'b1;
                if (!m_mem_write_q) begin
                    wb_reg_write_d = m_reg_write_q && (m_rd_q != 5'd0);
                    if (m_mem_to_reg_q) wb_data_d = ld_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            m_valid_q      <= 1'b0;
            m_alu_q        <= '0;
            m_data_q       <= '0;
            m_rd_q         <= '0;
            m_func3_q      <= '0;
            m_reg_write_q  <= 1'b0;
            m_mem_read_q   <= 1'b0;
            m_mem_write_q  <= 1'b0;
            m_mem_to_reg_q <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
        end else begin
            if (!mem_stall) begin
                m_valid_q      <= ex_valid;
                m_alu_q        <= ex_alu_result;
                m_data_q       <= ex_data;
                m_rd_q         <= ex_rd_addr;
                m_func3_q      <= ex_func3;
                m_reg_write_q  <= ex_reg_write;
                m_mem_read_q   <= ex_mem_read;
                m_mem_write_q  <= ex_mem_write;
                m_mem_to_reg_q <= ex_mem_to_reg;
            end
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd_addr   = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_reg_write = wb_reg_write_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized run
// against a byte-level memory model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        ex_valid = 1'b0, ex_reg_write = 1'b0, ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0, ex_mem_to_reg = 1'b0;
    logic [31:0] ex_alu_result = '0, ex_data = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic [2:0]  ex_func3 = '0;
    logic        mem_stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, fwd_data, wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  fwd_rd_addr, wb_rd_addr;
    logic        wb_valid, wb_reg_write, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    logic        dir_ready = 1'b0, resp_ready = 1'b0;
    logic [31:0] dir_rdata = '0, resp_rdata = '0;
    bit          resp_en = 1'b0;
    assign dmem_ready = resp_en ? resp_ready : dir_ready;
    assign dmem_rdata = resp_en ? resp_rdata : dir_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst_(rst_), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_data(ex_data), .ex_rd_addr(ex_rd_addr), .ex_func3(ex_func3),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data), .wb_valid(wb_valid),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .bus_err(bus_err)
    );

    // Memory model: byte array for expectations, word array behind the responder.
    logic [7:0]  mb [64];
    logic [31:0] rmem [16];
    int          r_wait = 0, r_delay = 0;

    always begin
        @(posedge clk);
        #2;
        if (resp_en && dmem_req) begin
            if (r_wait >= r_delay) begin
                resp_ready = 1'b1;
                resp_rdata = rmem[dmem_addr[5:2]];
                if (dmem_we)
                    for (int b = 0; b < 4; b++)
                        if (dmem_wstrb[b]) rmem[dmem_addr[5:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                r_wait  = 0;
                r_delay = $urandom_range(0, 4);
            end else begin
                resp_ready = 1'b0;
                resp_rdata = $urandom;
                r_wait++;
            end
        end else begin
            resp_ready = 1'b0;
        end
    end

    function automatic int access_bytes(input logic [2:0] f3, input bit is_store);
        if (is_store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
        int n = access_bytes(f3, 0);
        int base = {26'd0, addr[5:2], 2'b00};
        int start = (n == 1) ? int'(addr[1:0]) : (n == 2) ? (addr[1] ? 2 : 0) : 0;
        logic [31:0] v = '0;
        logic [31:0] mask;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + start + i]) << (8 * i));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [2:0] f3,
                               input logic [31:0] data);
        int n = access_bytes(f3, 1);
        int base = {26'd0, addr[5:2], 2'b00};
        int start = (n == 4) ? 0 : int'(addr[1:0]);
        for (int l = start; l < start + n && l < 4; l++) mb[base + l] = 8'(data >> (8 * (l % n)));
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] alu, input logic [31:0] data,
                            input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                            input logic mr, input logic mw);
        ex_valid = v; ex_alu_result = alu; ex_data = data; ex_rd_addr = rd; ex_func3 = f3;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = mr;
    endtask

    task automatic idle_ex();
        drive_ex(1'b0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        idle_ex();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_ = 1'b0;
        drive_ex(1'b1, 32'h40, 32'h0, 5'd2, 3'd2, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %0h exp 0", wb_valid); end
        checks++; if (wb_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_wb_rd got %0h exp 0", wb_rd_addr); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %0h exp 0", wb_data); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_rw got %0h exp 0", wb_reg_write); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h exp 0", mem_stall); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %0h exp 0", bus_err); end
        checks++; if (fwd_rd_addr !== 5'd0) begin errors++; $display("FAIL rst_fwd_rd got %0h exp 0", fwd_rd_addr); end
        @(posedge clk); #1;
        rst_ = 1'b1;
        settle();
    endtask

    task automatic test_alu();
        drive_ex(1'b1, 32'd30, 32'h0, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_early_wb got %0h exp 0", wb_valid); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %0h exp 0", dmem_req); end
        checks++; if (fwd_rd_addr !== 5'd3) begin errors++; $display("FAIL alu_fwd_rd got %0h exp 3", fwd_rd_addr); end
        checks++; if (fwd_data !== 32'd30) begin errors++; $display("FAIL alu_fwd_data got %0h exp 1e", fwd_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_rd_addr !== 5'd3) begin errors++; $display("FAIL alu_wb_rd got %0h exp 3", wb_rd_addr); end
        checks++; if (wb_data !== 32'd30) begin errors++; $display("FAIL alu_wb_data got %0h exp 1e", wb_data); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_wb_rw got %0h exp 1", wb_reg_write); end
        @(posedge clk); #1;
        settle();
    endtask

    task automatic test_lw_wait();
        dir_ready = 1'b0;
        drive_ex(1'b1, 32'd108, 32'h0, 5'd7, 3'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_ex(1'b1, 32'h999, 32'h0, 5'd9, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req got %0h exp 1", dmem_req); end
        checks++; if (dmem_addr !== 32'h6C) begin errors++; $display("FAIL lw_addr got %0h exp 6c", dmem_addr); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lw_we got %0h exp 0", dmem_we); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall1 got %0h exp 1", mem_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL lw_stall2 got %0h exp 1", mem_stall); end
        checks++; if (dmem_addr !== 32'h6C) begin errors++; $display("FAIL lw_hold_addr got %0h exp 6c", dmem_addr); end
        @(posedge clk); #1;
        dir_ready = 1'b1; dir_rdata = 32'h12345678;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lw_release got %0h exp 0", mem_stall); end
        @(posedge clk); #1;
        dir_ready = 1'b0; idle_ex();
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_data !== 32'h12345678) begin errors++; $display("FAIL lw_wb_data got %0h exp 12345678", wb_data); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL lw_wb_rw got %0h exp 1", wb_reg_write); end
        checks++; if (fwd_rd_addr !== 5'd9) begin errors++; $display("FAIL lw_next_fwd got %0h exp 9", fwd_rd_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wb_data !== 32'h999) begin errors++; $display("FAIL lw_next_wb got %0h exp 999", wb_data); end
        @(posedge clk); #1;
        settle();
    endtask

    task automatic test_sb();
        dir_ready = 1'b1;
        drive_ex(1'b1, 32'h101, 32'hDEADBEEF, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sb_we got %0h exp 1", dmem_we); end
        checks++; if (dmem_wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %0h exp 2", dmem_wstrb); end
        checks++; if (dmem_wdata !== 32'hEFEFEFEF) begin errors++; $display("FAIL sb_wdata got %0h exp efefefef", dmem_wdata); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr got %0h exp 100", dmem_addr); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL sb_stall got %0h exp 0", mem_stall); end
        @(posedge clk); #1;
        dir_ready = 1'b0;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sb_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL sb_wb_rw got %0h exp 0", wb_reg_write); end
        @(posedge clk); #1;
        settle();
    endtask

    task automatic test_lb_lbu();
        dir_ready = 1'b1; dir_rdata = 32'h80FF0000;
        drive_ex(1'b1, 32'h103, 32'h0, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_ex(1'b1, 32'h103, 32'h0, 5'd5, 3'd4, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL lb_stall got %0h exp 0", mem_stall); end
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        checks++; if (wb_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %0h exp ffffff80", wb_data); end
        checks++; if (wb_rd_addr !== 5'd4) begin errors++; $display("FAIL lb_rd got %0h exp 4", wb_rd_addr); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wb_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %0h exp 80", wb_data); end
        checks++; if (wb_rd_addr !== 5'd5) begin errors++; $display("FAIL lbu_rd got %0h exp 5", wb_rd_addr); end
        @(posedge clk); #1;
        dir_ready = 1'b0;
        settle();
    endtask

    task automatic test_timeout();
        int got = 0;
        dir_ready = 1'b0;
        drive_ex(1'b1, 32'h200, 32'h0, 5'd6, 3'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive_ex(1'b1, 32'h55, 32'h0, 5'd5, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus_err === 1'b1) begin got = n; break; end
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL to_stall cycle %0d got %0h exp 1", n, mem_stall); end
            @(posedge clk); #1;
        end
        checks++; if (got != 15) begin errors++; $display("FAIL to_cycle got %0d exp 15", got); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL to_release got %0h exp 0", mem_stall); end
        @(posedge clk); #1;
        idle_ex(); dir_ready = 1'b1;
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL to_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL to_wb_rw got %0h exp 0", wb_reg_write); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL to_pulse got %0h exp 0", bus_err); end
        checks++; if (fwd_rd_addr !== 5'd5) begin errors++; $display("FAIL to_next_fwd got %0h exp 5", fwd_rd_addr); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_late_req got %0h exp 0", dmem_req); end
        @(posedge clk); #1;
        dir_ready = 1'b0;
        @(negedge clk);
        checks++; if (wb_data !== 32'h55) begin errors++; $display("FAIL to_next_wb got %0h exp 55", wb_data); end
        @(posedge clk); #1;
        settle();
    endtask

    task automatic test_reset_busy();
        dir_ready = 1'b0;
        drive_ex(1'b1, 32'h104, 32'h0, 5'd1, 3'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_req got %0h exp 1", dmem_req); end
        @(posedge clk); #1;
        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rb_req_drop got %0h exp 0", dmem_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rb_stall got %0h exp 0", mem_stall); end
        settle();
    endtask

`ifdef MEM_MISALIGN_TRAP_EN
    task automatic test_misalign();
        dir_ready = 1'b1;
        drive_ex(1'b1, 32'h102, 32'h0, 5'd8, 3'd2, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1; idle_ex();
        @(negedge clk);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %0h exp 0", dmem_req); end
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL mis_pulse got %0h exp 1", misalign); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0h exp 0", mem_stall); end
        @(posedge clk); #1;
        dir_ready = 1'b0;
        @(negedge clk);
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_end got %0h exp 0", misalign); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mis_wb_valid got %0h exp 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_wb_rw got %0h exp 0", wb_reg_write); end
        @(posedge clk); #1;
        settle();
    endtask
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rw;
        bit          chk_data;
    } exp_t;

    task automatic test_random();
        localparam int NumOps = 300;
        exp_t q[$];
        exp_t e, got;
        int n_acc = 0;
        bit acc, mis;
        int n;
        logic c_v, c_rw, c_mr, c_mw;
        logic [31:0] c_alu, c_data;
        logic [4:0] c_rd;
        logic [2:0] c_f3;
        for (int k = 0; k < 64; k++) mb[k] = 8'($urandom);
        for (int w = 0; w < 16; w++) rmem[w] = {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
        r_wait = 0; r_delay = $urandom_range(0, 4);
        resp_en = 1'b1;
        c_v = 0; c_rw = 0; c_mr = 0; c_mw = 0; c_alu = 0; c_data = 0; c_rd = 0; c_f3 = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (cyc == 0 || acc) begin
                if (n_acc < NumOps) begin
                    int kind = $urandom_range(0, 3);
                    c_v = (kind != 3); c_mr = (kind == 1); c_mw = (kind == 2);
                    c_rd = 5'($urandom); c_f3 = 3'($urandom); c_rw = 1'($urandom);
                    c_data = $urandom;
                    c_alu = (c_mr || c_mw) ? 32'h100 + 32'($urandom_range(0, 63)) : $urandom;
                    drive_ex(c_v, c_alu, c_data, c_rd, c_f3, c_rw, c_mr, c_mw);
                end else begin
                    idle_ex();
                end
            end
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_wb rd %0d data %0h exp none", wb_rd_addr, wb_data);
                end else begin
                    got = q.pop_front();
                    if (wb_rd_addr !== got.rd || wb_reg_write !== got.rw ||
                        (got.chk_data && wb_data !== got.data)) begin
                        errors++;
                        $display("FAIL rnd_wb got rd=%0d rw=%0h data=%0h exp rd=%0d rw=%0h data=%0h",
                                 wb_rd_addr, wb_reg_write, wb_data, got.rd, got.rw, got.data);
                    end
                end
            end
            acc = (mem_stall === 1'b0);
            if (acc && n_acc < NumOps) begin
                n_acc++;
                if (c_v) begin
                    e.rd = c_rd; e.data = c_alu; e.chk_data = 1'b1;
                    e.rw = c_rw && (c_rd != 5'd0);
                    if (c_mr || c_mw) begin
                        n = access_bytes(c_f3, c_mw);
                        mis = (n == 2 && c_alu[0]) || (n == 4 && c_alu[1:0] != 2'b00);
`ifndef MEM_MISALIGN_TRAP_EN
                        mis = 1'b0;
`endif
                        if (mis || c_mw) begin
                            e.rw = 1'b0; e.chk_data = 1'b0;
                            if (!mis) model_store(c_alu, c_f3, c_data);
                        end else begin
                            e.data = model_load(c_alu, c_f3);
                        end
                    end
                    q.push_back(e);
                end
            end
            @(posedge clk); #1;
            if (n_acc >= NumOps && !c_v && q.size() == 0) break;
            if (n_acc >= NumOps) c_v = 1'b0;
        end
        checks++;
        if (q.size() != 0 || n_acc != NumOps) begin
            errors++; $display("FAIL rnd_drain got pending=%0d accepted=%0d exp 0 and %0d", q.size(), n_acc, NumOps);
        end
        resp_en = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw_wait();
        test_sb();
        test_lb_lbu();
        test_timeout();
        test_reset_busy();
`ifdef MEM_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
